exu_inst_queue: RTL and testbench

- Instruction queue between the fetch unit and the EXU decode/dispatch stage. It feeds the decoders that drive the per-class instruction handlers, such as the ALU-immediate handler.
- Buffers fetched {pc, inst} pairs in a small circular FIFO with valid/ready handshakes on both sides.
- Flushes on redirect (branch/jump taken).
- Provides a registered one-bit pre-decode of the OP-IMM class so the dispatcher can select the ALU-immediate path without re-decoding the opcode.

---
 rtl/exu_inst_queue.sv | 138 +++++++++++++
 tb/tb_exu_inst_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/exu_inst_queue.sv
// exu_inst_queue: circular FIFO of {pc, inst} pairs between fetch and EXU
// decode/dispatch. Each entry carries a one-bit OP-IMM pre-decode that is
// computed when the entry is pushed.
// Optional feature macro: EXU_INST_QUEUE_BYPASS_EN. When it is defined, an
// empty queue passes the input straight to the output in the same cycle.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  drop all entries on the next rising edge
//   in_vld/in_rdy          fetch-side handshake; in_pc, in_inst are the payload
//   out_vld/out_rdy        EXU-side handshake; out_pc, out_inst, out_is_alu_imm
//   count                  number of occupied entries
module exu_inst_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_inst,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_inst,
  output logic                     out_is_alu_imm,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [6:0]  OP_IMM = 7'b0010011;

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [DEPTH-1:0] alu_mem;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic byp_take;
  logic in_is_alu_imm;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count  = wr_ptr - rd_ptr;

  assign in_is_alu_imm = (in_inst[6:0] == OP_IMM);

  // Ready is forced low while reset is held; the pointers already read empty.
  assign in_rdy = rst_n & ~full & ~flush;

`ifdef EXU_INST_QUEUE_BYPASS_EN
  logic byp_act;

  // Transparent path: only when nothing is stored and no flush is pending.
  assign byp_act  = rst_n & empty & ~flush;
  assign byp_take = byp_act & in_vld & out_rdy;

  always_comb begin
    out_vld        = 1'b0;
    out_pc         = '0;
    out_inst       = '0;
    out_is_alu_imm = 1'b0;
    if (byp_act) begin
      out_vld = in_vld;
      if (in_vld) begin
        out_pc         = in_pc;
        out_inst       = in_inst;
        out_is_alu_imm = in_is_alu_imm;
      end
    end else if (!empty) begin
      out_vld        = 1'b1;
      out_pc         = pc_mem[rd_idx];
      out_inst       = inst_mem[rd_idx];
      out_is_alu_imm = alu_mem[rd_idx];
    end
  end
`else
  assign byp_take = 1'b0;

  // Head entry, zeroed while empty.
  always_comb begin
    out_vld        = ~empty;
    out_pc         = '0;
    out_inst       = '0;
    out_is_alu_imm = 1'b0;
    if (!empty) begin
      out_pc         = pc_mem[rd_idx];
      out_inst       = inst_mem[rd_idx];
      out_is_alu_imm = alu_mem[rd_idx];
    end
  end
`endif

  // A bypassed entry is consumed directly and never written.
  assign push = in_vld & in_rdy & ~byp_take;
  // Pop only from storage; a pop coinciding with flush is discarded.
  assign pop  = ~empty & out_rdy & ~flush;

  // Pointer update; flush wins over any handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Entry storage with the pre-decode bit captured at push time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
      alu_mem <= '0;
    end else if (push) begin
      pc_mem[wr_idx]   <= in_pc;
      inst_mem[wr_idx] <= in_inst;
      alu_mem[wr_idx]  <= in_is_alu_imm;
    end
  end

endmodule

// File: tb/tb_exu_inst_queue.sv
// Self-checking bench for exu_inst_queue: reset, a directed vector table,
// wrap-around streaming, async reset, and random traffic against a
// queue-based reference model.
module tb_exu_inst_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;
  localparam logic [31:0] ADDI  = 32'h0050_0093;
  localparam logic [31:0] ADD   = 32'h0000_0033;
`ifdef EXU_INST_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_vld;
  logic            in_rdy;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_inst;
  logic            out_vld;
  logic            out_rdy;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;
  logic            out_is_alu_imm;
  logic [2:0]      count;

  exu_inst_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_pc(in_pc), .in_inst(in_inst),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_pc(out_pc), .out_inst(out_inst),
    .out_is_alu_imm(out_is_alu_imm), .count(count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  typedef struct {
    logic        vld, rdy, fl;
    logic [31:0] pc, inst;
    logic [2:0]  e_cnt;
    logic        e_vld, e_alu, e_irdy;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  vec_t vecs[10];
  ent_t q[$];

  task automatic idle();
    in_vld = 1'b0; out_rdy = 1'b0; flush = 1'b0; in_pc = '0; in_inst = '0;
  endtask

  initial begin
    int nr, ns, cyc, sz;
    bit byp;
    logic e_vld, e_alu, e_rdy;
    logic [31:0] e_pc, e_inst;

    // vld rdy fl pc inst | count vld alu in_rdy pc inst (after edge, idle inputs)
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, ADDI, 3'd1, 1'b1, 1'b1, 1'b1, 32'h100, ADDI};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h104, ADD,  3'd2, 1'b1, 1'b1, 1'b1, 32'h100, ADDI};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h108, ADD,  3'd3, 1'b1, 1'b1, 1'b1, 32'h100, ADDI};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h10C, ADD,  3'd4, 1'b1, 1'b1, 1'b0, 32'h100, ADDI};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h110, ADD,  3'd4, 1'b1, 1'b1, 1'b0, 32'h100, ADDI};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h110, ADD,  3'd3, 1'b1, 1'b0, 1'b1, 32'h104, ADD};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h110, ADD,  3'd4, 1'b1, 1'b0, 1'b0, 32'h104, ADD};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h0, 3'd3, 1'b1, 1'b0, 1'b1, 32'h108, ADD};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 32'h114, ADDI, 3'd0, 1'b0, 1'b0, 1'b1, 32'h0,   32'h0};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 32'h200, ADDI, 3'd1, 1'b1, 1'b1, 1'b1, 32'h200, ADDI};

    // Reset held for 3 cycles.
    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rdy_low", in_rdy, 0);
    chk("rst_out_vld", out_vld, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_vld_after", out_vld, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_in_rdy", in_rdy, 1);

    // Directed table: fill, full+pop, flush, refill after flush.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_vld = vecs[i].vld; out_rdy = vecs[i].rdy; flush = vecs[i].fl;
      in_pc = vecs[i].pc; in_inst = vecs[i].inst;
      @(posedge clk); #1;
      idle();
      #1;
      chk($sformatf("vec%0d_count", i), count, vecs[i].e_cnt);
      chk($sformatf("vec%0d_out_vld", i), out_vld, vecs[i].e_vld);
      chk($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d_out_inst", i), out_inst, vecs[i].e_inst);
      chk($sformatf("vec%0d_alu_imm", i), out_is_alu_imm, vecs[i].e_alu);
      chk($sformatf("vec%0d_in_rdy", i), in_rdy, vecs[i].e_irdy);
    end

    // Drain, then stream 10 entries with out_rdy toggling.
    @(posedge clk); #1;
    out_rdy = 1'b1;
    repeat (DEPTH + 1) @(posedge clk);
    #1;
    out_rdy = 1'b0;
    #1;
    chk("drain_empty", out_vld, 0);
    nr = 0; ns = 0; cyc = 0;
    while (nr < 10 && cyc < 80) begin
      @(posedge clk); #1;
      in_vld  = (ns < 10);
      in_pc   = 32'(ns * 4);
      in_inst = (ns % 2 == 0) ? ADDI : ADD;
      out_rdy = ~cyc[0];
      #3;
      chk("wrap_count_le4", 64'(count > 3'd4), 0);
      if (out_vld && out_rdy) begin
        chk("wrap_order", out_pc, 64'(nr * 4));
        nr++;
      end
      if (in_vld && in_rdy) ns++;
      cyc++;
    end
    chk("wrap_all_out", 64'(nr), 10);
    @(posedge clk); #1;
    idle();

`ifdef EXU_INST_QUEUE_BYPASS_EN
    // Bypass through an empty queue.
    out_rdy = 1'b1;
    repeat (DEPTH + 1) @(posedge clk);
    #1;
    in_vld = 1'b1; in_pc = 32'h200; in_inst = ADDI; out_rdy = 1'b1;
    #1;
    chk("byp_out_vld", out_vld, 1);
    chk("byp_out_pc", out_pc, 32'h200);
    @(posedge clk); #1;
    idle();
    #1;
    chk("byp_count0", count, 0);
    in_vld = 1'b1; in_pc = 32'h200; in_inst = ADDI; out_rdy = 1'b0;
    @(posedge clk); #1;
    idle();
    #1;
    chk("byp_count1", count, 1);
    chk("byp_head_pc", out_pc, 32'h200);
    @(posedge clk); #1;
`endif

    // Random traffic against the reference queue; start from empty.
    out_rdy = 1'b1;
    repeat (DEPTH + 1) @(posedge clk);
    #1;
    idle();
    q.delete();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      in_vld  = 1'($urandom_range(1, 0));
      out_rdy = 1'($urandom_range(1, 0));
      flush   = ($urandom_range(15, 0) == 0);
      in_pc   = $urandom;
      in_inst = $urandom;
      if ($urandom_range(1, 0) == 1) in_inst[6:0] = 7'b0010011;
      #3;
      sz    = q.size();
      byp   = BYP && sz == 0 && !flush && in_vld;
      e_vld = (sz > 0) || byp;
      e_pc  = (sz > 0) ? q[0].pc : (byp ? in_pc : 32'h0);
      e_inst = (sz > 0) ? q[0].inst : (byp ? in_inst : 32'h0);
      e_alu = e_vld && (e_inst[6:0] == 7'b0010011);
      e_rdy = (sz < int'(DEPTH)) && !flush;
      chk("rnd_out_vld", out_vld, e_vld);
      chk("rnd_out_pc", out_pc, e_pc);
      chk("rnd_out_inst", out_inst, e_inst);
      chk("rnd_alu_imm", out_is_alu_imm, e_alu);
      chk("rnd_count", count, 64'(sz));
      chk("rnd_in_rdy", in_rdy, e_rdy);
      if (flush) q.delete();
      else if (!(byp && out_rdy)) begin
        if (out_rdy && sz > 0) void'(q.pop_front());
        if (in_vld && sz < int'(DEPTH)) q.push_back('{pc: in_pc, inst: in_inst});
      end
    end

    // Asynchronous reset mid-operation with entries held.
    @(posedge clk); #1;
    idle();
    in_vld = 1'b1; in_pc = 32'h300; in_inst = ADDI;
    @(posedge clk); #1;
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_vld", out_vld, 0);
    chk("arst_count", count, 0);
    chk("arst_out_pc", out_pc, 0);
    chk("arst_in_rdy", in_rdy, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
